// File: rtl/demux16_reg_bank_pkg.sv
// Shared constants for the 16-slot write-side register bank feeding the ATM 16:1 word mux.
package demux16_reg_bank_pkg;
  localparam int SLOTS = 16;
  localparam int IDX_W = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic logic [SLOTS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(SLOTS-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/demux16_reg_bank_slot_reg.sv
// One bank slot: WIDTH-bit register with sync active-low reset, clear and write enable.
module demux16_reg_bank_slot_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n)   r_q <= CLR_VAL;
    else if (clr) r_q <= CLR_VAL;
    else if (we)  r_q <= d;
  end

  assign q = r_q;
endmodule

// File: rtl/demux16_reg_bank.sv
// 1-to-16 register bank: addressed single writes or a 16-byte valid/ready stream load,
// with a per-slot valid mask. Slot outputs drive the 16:1 word mux directly.
module demux16_reg_bank
  import demux16_reg_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             S3,
  input  logic             S2,
  input  logic             S1,
  input  logic             S0,
  input  logic             WE,
  input  logic [WIDTH-1:0] Data,
  input  logic             Start,
  input  logic             InValid,
  input  logic             Clr,
  output logic             InReady,
  output logic             Busy,
  output logic             Done,
  output logic             Full,
  output logic [15:0]      VMask,
  output logic [WIDTH-1:0] W0,
  output logic [WIDTH-1:0] W1,
  output logic [WIDTH-1:0] W2,
  output logic [WIDTH-1:0] W3,
  output logic [WIDTH-1:0] W4,
  output logic [WIDTH-1:0] W5,
  output logic [WIDTH-1:0] W6,
  output logic [WIDTH-1:0] W7,
  output logic [WIDTH-1:0] W8,
  output logic [WIDTH-1:0] W9,
  output logic [WIDTH-1:0] W10,
  output logic [WIDTH-1:0] W11,
  output logic [WIDTH-1:0] W12,
  output logic [WIDTH-1:0] W13,
  output logic [WIDTH-1:0] W14,
  output logic [WIDTH-1:0] W15
);
  logic [1:0]                   r_state;
  logic [IDX_W-1:0]             r_ptr;
  logic [SLOTS-1:0]             r_vmask;
  logic [IDX_W-1:0]             w_addr;
  logic                         w_strm_wr;
  logic                         w_sgl_wr;
  logic [SLOTS-1:0]             w_wr_sel;
  logic [SLOTS-1:0][WIDTH-1:0]  w_slots;

  assign w_addr = {S3, S2, S1, S0};

  // Clr and Start both outrank any write in the same cycle.
  assign w_strm_wr = (r_state == ST_LOAD) && InValid && !Start && !Clr;
  assign w_sgl_wr  = (r_state == ST_IDLE) && WE && !Start && !Clr;
  assign w_wr_sel  = w_strm_wr ? onehot(r_ptr)
                   : w_sgl_wr  ? onehot(w_addr)
                   : '0;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_vmask <= '0;
    end else begin
      if (Clr) r_vmask <= '0;
      else     r_vmask <= r_vmask | w_wr_sel;

      // Clr leaves the stream position alone; only the DONE pulse still retires.
      if (Clr) begin
        if (r_state == ST_DONE) r_state <= ST_IDLE;
      end else if (Start) begin
        r_state <= ST_LOAD;
        r_ptr   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_LOAD: if (InValid) begin
            r_ptr <= r_ptr + 1'b1;
            if (&r_ptr) r_state <= ST_DONE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    demux16_reg_bank_slot_reg #(
      .WIDTH   (WIDTH),
      .CLR_VAL (CLR_VAL)
    ) u_slot (
      .clk   (Clock),
      .rst_n (Resetn),
      .clr   (Clr),
      .we    (w_wr_sel[g]),
      .d     (Data),
      .q     (w_slots[g])
    );
  end

  assign InReady = (r_state == ST_LOAD);
  assign Busy    = (r_state != ST_IDLE);
  assign Done    = (r_state == ST_DONE);
  assign VMask   = r_vmask;
  assign Full    = &r_vmask;

  assign W0  = w_slots[0];
  assign W1  = w_slots[1];
  assign W2  = w_slots[2];
  assign W3  = w_slots[3];
  assign W4  = w_slots[4];
  assign W5  = w_slots[5];
  assign W6  = w_slots[6];
  assign W7  = w_slots[7];
  assign W8  = w_slots[8];
  assign W9  = w_slots[9];
  assign W10 = w_slots[10];
  assign W11 = w_slots[11];
  assign W12 = w_slots[12];
  assign W13 = w_slots[13];
  assign W14 = w_slots[14];
  assign W15 = w_slots[15];
endmodule

// File: tb/tb_demux16_reg_bank.sv
// Bench for demux16_reg_bank: directed plan plus random traffic against a slot-array model.
module tb_demux16_reg_bank;
  logic        Clock = 1'b0;
  logic        Resetn, WE, Start, InValid, Clr;
  logic [3:0]  sel;
  logic [7:0]  Data;
  logic        InReady, Busy, Done, Full;
  logic [15:0] VMask;
  logic [7:0]  W0, W1, W2, W3, W4, W5, W6, W7, W8, W9, W10, W11, W12, W13, W14, W15;
  logic [15:0][7:0] w_all;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: plain slot array, mask, stream position and a mode tag.
  logic [15:0][7:0] m_w;
  logic [15:0]      m_vm;
  int               m_ptr;
  int               m_mode; // 0 idle, 1 loading, 2 done pulse

  always #5 Clock = ~Clock;

  demux16_reg_bank dut (
    .Clock(Clock), .Resetn(Resetn),
    .S3(sel[3]), .S2(sel[2]), .S1(sel[1]), .S0(sel[0]),
    .WE(WE), .Data(Data), .Start(Start), .InValid(InValid), .Clr(Clr),
    .InReady(InReady), .Busy(Busy), .Done(Done), .Full(Full), .VMask(VMask),
    .W0(W0), .W1(W1), .W2(W2), .W3(W3), .W4(W4), .W5(W5), .W6(W6), .W7(W7),
    .W8(W8), .W9(W9), .W10(W10), .W11(W11), .W12(W12), .W13(W13), .W14(W14), .W15(W15)
  );

  assign w_all = {W15, W14, W13, W12, W11, W10, W9, W8, W7, W6, W5, W4, W3, W2, W1, W0};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(posedge Clock) begin
    logic [15:0][7:0] w;
    logic [15:0]      vm;
    int               p, md;
    w = m_w; vm = m_vm; p = m_ptr; md = m_mode;
    if (!Resetn) begin
      w = '0; vm = '0; p = 0; md = 0;
    end else if (Clr) begin
      w = '0; vm = '0;
      if (md == 2) md = 0;
    end else if (Start) begin
      md = 1; p = 0;
    end else if (md == 1) begin
      if (InValid) begin
        w[p] = Data; vm[p] = 1'b1;
        if (p == 15) md = 2;
        p = (p + 1) % 16;
      end
    end else if (md == 2) begin
      md = 0;
    end else if (WE) begin
      w[sel] = Data; vm[sel] = 1'b1;
    end
    m_w <= w; m_vm <= vm; m_ptr <= p; m_mode <= md;
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("slots",   w_all,   m_w);
      chk("vmask",   VMask,   m_vm);
      chk("full",    Full,    &m_vm);
      chk("inready", InReady, m_mode == 1);
      chk("busy",    Busy,    m_mode != 0);
      chk("done",    Done,    m_mode == 2);
    end
  end

  task automatic idle_in();
    Resetn = 1'b1; WE = 1'b0; Start = 1'b0; InValid = 1'b0; Clr = 1'b0;
  endtask

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic do_reset();
    idle_in(); Resetn = 1'b0; step(); idle_in();
  endtask

  initial begin
    idle_in(); sel = '0; Data = '0;
    do_reset();
    chk_en = 1'b1;

    // prior contents, then reset clears everything
    WE = 1; sel = 4'd3; Data = 8'h77; step(); idle_in();
    do_reset();
    chk("rst_w",    w_all,   128'h0);
    chk("rst_vm",   VMask,   16'h0000);
    chk("rst_full", Full,    1'b0);
    chk("rst_rdy",  InReady, 1'b0);

    // single writes
    WE = 1; sel = 4'b0101; Data = 8'hA5; step();
    chk("sw_w5",  W5,    8'hA5);
    chk("sw_vm1", VMask, 16'h0020);
    sel = 4'b1111; Data = 8'h3C; step(); idle_in();
    chk("sw_w15", W15,   8'h3C);
    chk("sw_vm2", VMask, 16'h8020);
    chk("sw_w4",  W4,    8'h00);

    // full stream
    Start = 1; step(); idle_in();
    chk("st_rdy", InReady, 1'b1);
    for (int i = 0; i < 16; i++) begin
      InValid = 1; Data = 8'h10 + 8'(i); step();
      if (i < 15) chk("st_nodone", Done, 1'b0);
    end
    idle_in();
    chk("st_done", Done,  1'b1);
    chk("st_w3",   W3,    8'h13);
    chk("st_w15",  W15,   8'h1F);
    chk("st_full", Full,  1'b1);
    step();
    chk("st_done_end", Done,    1'b0);
    chk("st_rdy_end",  InReady, 1'b0);

    // stall with WE blocked
    Clr = 1; step(); idle_in();
    Start = 1; step(); idle_in();
    WE = 1; sel = 4'b0000;
    InValid = 1; Data = 8'h55; step();
    InValid = 0; Data = 8'h66; step();
    InValid = 1; Data = 8'h77; step(); idle_in();
    chk("stall_vm", VMask, 16'h0003);
    chk("stall_w0", W0,    8'h55);
    chk("stall_w1", W1,    8'h77);

    // Clr mid-stream
    do_reset();
    Start = 1; step(); idle_in();
    for (int i = 0; i < 5; i++) begin InValid = 1; Data = 8'hC0 + 8'(i); step(); end
    Clr = 1; Data = 8'hEE; step(); Clr = 0;
    chk("clr_vm", VMask, 16'h0000);
    chk("clr_w",  w_all, 128'h0);
    Data = 8'h99; step(); idle_in();
    chk("clr_w5", W5,    8'h99);
    chk("clr_vm5", VMask, 16'h0020);

    // reset mid-stream
    do_reset();
    Start = 1; step(); idle_in();
    for (int i = 0; i < 8; i++) begin InValid = 1; Data = 8'hD0 + 8'(i); step(); end
    do_reset();
    chk("rms_busy", Busy,  1'b0);
    chk("rms_vm",   VMask, 16'h0000);
    Start = 1; step(); idle_in();
    InValid = 1; Data = 8'h42; step(); idle_in();
    chk("rms_w0", W0,    8'h42);
    chk("rms_vm0", VMask, 16'h0001);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      Resetn  = ($urandom_range(0, 127) != 0);
      Clr     = ($urandom_range(0, 47) == 0);
      Start   = ($urandom_range(0, 39) == 0);
      InValid = ($urandom_range(0, 3) != 0);
      WE      = ($urandom_range(0, 1) == 1);
      sel     = 4'($urandom_range(0, 15));
      Data    = 8'($urandom);
      step();
    end
    idle_in(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
